rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob.sv | 120 ++++++++++++
 tb/tb_rob.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: circular buffer of in-flight instructions that retires results in program order.
// Operand lookups can see a result in the same cycle it appears on the CDB.
module rob #(
  parameter int ROB_ENTRY_NUM   = 16,
  parameter int ROB_ENTRY_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  input  logic                       alloc_has_dst,
  input  logic [4:0]                 alloc_rd,
  output logic                       alloc_ready,
  output logic [ROB_ENTRY_WIDTH-1:0] alloc_index,
  input  logic                       cdb_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] cdb_index,
  input  logic [31:0]                cdb_data,
  input  logic [ROB_ENTRY_WIDTH-1:0] q1_index,
  input  logic [ROB_ENTRY_WIDTH-1:0] q2_index,
  output logic                       q1_ready,
  output logic                       q2_ready,
  output logic [31:0]                q1_data,
  output logic [31:0]                q2_data,
  output logic                       ROB_we,
  output logic [4:0]                 ROB_waddr,
  output logic [31:0]                ROB_wdata,
  output logic                       commit_valid,
  output logic [ROB_ENTRY_WIDTH-1:0] commit_index,
  input  logic                       flush,
  output logic                       empty,
  output logic                       full,
  output logic [ROB_ENTRY_WIDTH:0]   count
);

  typedef logic [ROB_ENTRY_WIDTH:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  logic [ROB_ENTRY_NUM-1:0] ent_busy;
  logic [ROB_ENTRY_NUM-1:0] ent_ready;
  logic [ROB_ENTRY_NUM-1:0] ent_has_dst;
  logic [4:0]               ent_rd    [ROB_ENTRY_NUM];
  logic [31:0]              ent_value [ROB_ENTRY_NUM];

  ptr_t head;
  ptr_t tail;
  logic [ROB_ENTRY_WIDTH-1:0] head_idx;
  logic [ROB_ENTRY_WIDTH-1:0] tail_idx;
  logic do_alloc;
  logic do_commit;
  logic q1_bypass;
  logic q2_bypass;

  // The extra top pointer bit separates the full and empty cases when the indices match.
  assign head_idx    = head[ROB_ENTRY_WIDTH-1:0];
  assign tail_idx    = tail[ROB_ENTRY_WIDTH-1:0];
  assign empty       = (head == tail);
  assign full        = (head_idx == tail_idx) && (head[ROB_ENTRY_WIDTH] != tail[ROB_ENTRY_WIDTH]);
  assign count       = tail - head;
  assign alloc_ready = !full;
  assign alloc_index = tail_idx;

  // Commit looks only at registered ready, so a same-cycle CDB hit on head waits one edge.
  assign do_alloc  = alloc_valid && !full;
  assign do_commit = ent_busy[head_idx] && ent_ready[head_idx];

  assign q1_bypass = cdb_valid && (cdb_index == q1_index) && ent_busy[q1_index];
  assign q2_bypass = cdb_valid && (cdb_index == q2_index) && ent_busy[q2_index];
  assign q1_ready  = ent_ready[q1_index] || q1_bypass;
  assign q2_ready  = ent_ready[q2_index] || q2_bypass;
  assign q1_data   = q1_bypass ? cdb_data : ent_value[q1_index];
  assign q2_data   = q2_bypass ? cdb_data : ent_value[q2_index];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      ent_busy     <= '0;
      ent_ready    <= '0;
      ent_has_dst  <= '0;
      for (int i = 0; i < ROB_ENTRY_NUM; i++) begin
        ent_rd[i]    <= 5'd0;
        ent_value[i] <= 32'd0;
      end
      commit_valid <= 1'b0;
      commit_index <= '0;
      ROB_we       <= 1'b0;
      ROB_waddr    <= 5'd0;
      ROB_wdata    <= 32'd0;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      ent_busy     <= '0;
      ent_ready    <= '0;
      commit_valid <= 1'b0;
      ROB_we       <= 1'b0;
    end else begin
      commit_valid <= do_commit;
      ROB_we       <= do_commit && ent_has_dst[head_idx] && (ent_rd[head_idx] != 5'd0);
      if (do_commit) begin
        commit_index       <= head_idx;
        ROB_waddr          <= ent_rd[head_idx];
        ROB_wdata          <= ent_value[head_idx];
        ent_busy[head_idx] <= 1'b0;
        head               <= head + PTR_ONE;
      end
      if (cdb_valid && ent_busy[cdb_index]) begin
        ent_ready[cdb_index] <= 1'b1;
        ent_value[cdb_index] <= cdb_data;
      end
      // The tail slot is never busy when not full, so this cannot collide with the CDB write.
      if (do_alloc) begin
        ent_busy[tail_idx]    <= 1'b1;
        ent_ready[tail_idx]   <= 1'b0;
        ent_has_dst[tail_idx] <= alloc_has_dst;
        ent_rd[tail_idx]      <= alloc_rd;
        tail                  <= tail + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: a queue-based program-order model predicts commits,
// and a separate monitor checks each commit pulse against the expected queue.
module tb_rob;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         alloc_valid, alloc_has_dst;
  logic [4:0]   alloc_rd;
  logic         alloc_ready;
  logic [W-1:0] alloc_index;
  logic         cdb_valid;
  logic [W-1:0] cdb_index;
  logic [31:0]  cdb_data;
  logic [W-1:0] q1_index, q2_index;
  logic         q1_ready, q2_ready;
  logic [31:0]  q1_data, q2_data;
  logic         ROB_we;
  logic [4:0]   ROB_waddr;
  logic [31:0]  ROB_wdata;
  logic         commit_valid;
  logic [W-1:0] commit_index;
  logic         flush;
  logic         empty, full;
  logic [W:0]   count;

  rob #(.ROB_ENTRY_NUM(N), .ROB_ENTRY_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_has_dst(alloc_has_dst), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_data(cdb_data),
    .q1_index(q1_index), .q2_index(q2_index),
    .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_data(q1_data), .q2_data(q2_data),
    .ROB_we(ROB_we), .ROB_waddr(ROB_waddr), .ROB_wdata(ROB_wdata),
    .commit_valid(commit_valid), .commit_index(commit_index),
    .flush(flush), .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit has_dst; bit [4:0] rd; bit rdy; bit [31:0] val; } ent_t;
  typedef struct { int cyc; int idx; bit we; bit [4:0] waddr; bit [31:0] wdata; } cmt_t;

  ent_t model[$];
  cmt_t expq[$];
  int   mtail = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkLookup(input string name, input int qi, input logic rdy, input logic [31:0] data);
    bit bypass;
    for (int i = 0; i < model.size(); i++) begin
      if (model[i].idx == qi) begin
        bypass = cdb_valid && (int'(cdb_index) == qi);
        check({name, "_ready"}, 32'(rdy), 32'(model[i].rdy || bypass));
        if (bypass) check({name, "_bypass_data"}, data, cdb_data);
        else if (model[i].rdy) check({name, "_data"}, data, model[i].val);
      end
    end
  endtask

  // Combinational status and lookup outputs against the model state before the coming edge.
  task automatic checkOutput();
    check("count", 32'(count), 32'(model.size()));
    check("empty", 32'(empty), 32'(model.size() == 0));
    check("full", 32'(full), 32'(model.size() == N));
    check("alloc_ready", 32'(alloc_ready), 32'(model.size() < N));
    check("alloc_index", 32'(alloc_index), 32'(mtail));
    checkLookup("q1", int'(q1_index), q1_ready, q1_data);
    checkLookup("q2", int'(q2_index), q2_ready, q2_data);
  endtask

  task automatic applyStimulus(input bit av, input bit hd, input bit [4:0] r, input bit cv,
                               input int ci, input bit [31:0] cd, input bit fl,
                               input int q1, input int q2);
    int   pre;
    bit   cm;
    cmt_t c;
    ent_t e;
    @(negedge clk);
    alloc_valid = av; alloc_has_dst = hd; alloc_rd = r;
    cdb_valid = cv; cdb_index = W'(ci); cdb_data = cd;
    flush = fl; q1_index = W'(q1); q2_index = W'(q2);
    #1;
    checkOutput();
    if (fl) begin
      model.delete();
      mtail = 0;
    end else begin
      pre = model.size();
      cm  = (pre > 0) && model[0].rdy;
      if (cm) begin
        c.cyc = cyc + 1; c.idx = model[0].idx;
        c.we = model[0].has_dst && (model[0].rd != 5'd0);
        c.waddr = model[0].rd; c.wdata = model[0].val;
        expq.push_back(c);
      end
      if (cv)
        for (int i = 0; i < model.size(); i++)
          if (model[i].idx == ci) begin model[i].rdy = 1'b1; model[i].val = cd; end
      if (cm) void'(model.pop_front());
      if (av && pre < N) begin
        e.idx = mtail; e.has_dst = hd; e.rd = r; e.rdy = 1'b0; e.val = 32'd0;
        model.push_back(e);
        mtail = (mtail + 1) % N;
      end
    end
  endtask

  task automatic alloc(input bit [4:0] r, input bit hd);
    applyStimulus(1'b1, hd, r, 1'b0, 0, 32'd0, 1'b0, 0, 0);
  endtask
  task automatic cdb(input int i, input bit [31:0] d);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, i, d, 1'b0, 0, 0);
  endtask
  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 0, 32'd0, 1'b0, 0, 0);
  endtask
  task automatic doFlush();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 0, 32'd0, 1'b1, 0, 0);
  endtask

  // Asynchronous reset between edges: registered commit outputs must clear immediately.
  task automatic doReset();
    @(negedge clk);
    alloc_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    model.delete();
    mtail = 0;
    #1;
    check("reset_commit_valid", 32'(commit_valid), 32'd0);
    check("reset_rob_we", 32'(ROB_we), 32'd0);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every commit pulse must match the oldest expected commit at the predicted edge.
  always @(posedge clk) begin
    cmt_t c;
    #1;
    if (commit_valid) begin
      if (expq.size() == 0) check("unexpected_commit", 32'd1, 32'd0);
      else begin
        c = expq.pop_front();
        check("commit_cycle", 32'(cyc), 32'(c.cyc));
        check("commit_index", 32'(commit_index), 32'(c.idx));
        check("rob_we", 32'(ROB_we), 32'(c.we));
        check("rob_waddr", 32'(ROB_waddr), 32'(c.waddr));
        check("rob_wdata", ROB_wdata, c.wdata);
      end
    end else begin
      check("rob_we_idle", 32'(ROB_we), 32'd0);
      if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        check("missing_commit", 32'd0, 32'd1);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ci;
    rst_n = 1'b0;
    alloc_valid = 1'b0; alloc_has_dst = 1'b0; alloc_rd = 5'd0;
    cdb_valid = 1'b0; cdb_index = '0; cdb_data = 32'd0;
    flush = 1'b0; q1_index = '0; q2_index = '0;
    repeat (2) @(negedge clk);
    checkOutput();
    check("init_commit_valid", 32'(commit_valid), 32'd0);
    rst_n = 1'b1;

    // Single instruction round trip.
    alloc(5'd5, 1'b1);
    cdb(0, 32'hDEADBEEF);
    idle();
    idle();

    // Fill to capacity, overflow attempt, then retire one and wrap the tail.
    doFlush();
    for (int i = 0; i < N; i++) alloc(5'(i + 1), 1'b1);
    alloc(5'd30, 1'b1);
    cdb(0, 32'h0000_1111);
    idle();
    alloc(5'd9, 1'b1);
    idle();

    // Out-of-order completion retires in order.
    doFlush();
    for (int i = 0; i < 3; i++) alloc(5'(i + 10), 1'b1);
    cdb(2, 32'h2222);
    cdb(1, 32'h1111);
    idle();
    cdb(0, 32'h0);
    repeat (4) idle();

    // Same-cycle CDB bypass on lookup.
    doFlush();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 3, 32'h1234, 1'b0, 3, 2);
    tests++;
    if (!(q1_ready === 1'b1 && q1_data === 32'h1234)) begin
      fails++;
      $display("[TB] FAIL bypass_q1: got ready=%0b data=0x%0h expected ready=1 data=0x1234", q1_ready, q1_data);
    end

    // Commits that must not write the register file.
    doFlush();
    alloc(5'd0, 1'b1);
    alloc(5'd7, 1'b0);
    cdb(0, 32'hAAAA);
    cdb(1, 32'hBBBB);
    repeat (3) idle();

    // Flush and reset with work in flight.
    for (int i = 0; i < 5; i++) alloc(5'(i + 3), 1'b1);
    cdb(model[0].idx, 32'h55);
    doFlush();
    idle();
    for (int i = 0; i < 5; i++) alloc(5'(i + 3), 1'b1);
    cdb(model[0].idx, 32'h66);
    doReset();
    idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if (model.size() > 0 && $urandom_range(3) != 0)
        ci = model[$urandom_range(model.size() - 1)].idx;
      else
        ci = int'($urandom_range(N - 1));
      applyStimulus($urandom_range(3) != 0, 1'($urandom), 5'($urandom), $urandom_range(2) != 0,
                    ci, $urandom, $urandom_range(49) == 0,
                    int'($urandom_range(N - 1)), int'($urandom_range(N - 1)));
    end

    doFlush();
    repeat (2) idle();
    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
